// File: rtl/hsv_core_pkg.sv
// Shared types and defaults for the hsv_core issue-stage scoreboard.
package hsv_core_pkg;

    // Default geometry of the architectural register file
    localparam int SB_NUM_REGS = 32;
    localparam int SB_ADDR_W   = $clog2(SB_NUM_REGS);

    // Default width of each per-register pending-write counter
    localparam int SB_CNT_W    = 2;

    // Default writeback port count and payload width
    localparam int SB_NUM_WB   = 2;
    localparam int SB_DATA_W   = 64;

    typedef logic [SB_ADDR_W-1:0] reg_addr_t;
    typedef logic [SB_CNT_W-1:0]  sb_cnt_t;

    // One writeback retirement port
    typedef struct packed {
        logic      valid;
        reg_addr_t addr;
    } wb_port_t;

    // Largest value a pending counter of the given width can hold
    function automatic int sb_cnt_max(input int cnt_w);
        return (1 << cnt_w) - 1;
    endfunction

endpackage

// File: rtl/hsv_core_issue_scoreboard_cnt.sv
// Per-register pending-write counter: +1 on issue, -n on n retirements,
// clamps at zero and reports underflow; clear wins over everything.
module hsv_core_issue_scoreboard_cnt
    import hsv_core_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int DEC_W = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic [DEC_W-1:0] i_dec,
    output logic [CNT_W-1:0] o_value,
    output logic             o_underflow
);

    localparam int MAX = sb_cnt_max(CNT_W);

    logic [CNT_W-1:0] r_value;
    logic [CNT_W-1:0] w_next;
    int               w_net;

    // Net next count with underflow clamp; clear discards same-cycle events
    always_comb begin
        w_net       = int'(r_value) + int'(i_inc) - int'(i_dec);
        w_next      = r_value;
        o_underflow = 1'b0;
        if (i_clr) begin
            w_next = '0;
        end else if (w_net < 0) begin
            w_next      = '0;
            o_underflow = 1'b1;
        end else if (w_net > MAX) begin
            w_next = '1;
        end else begin
            w_next = CNT_W'(w_net);
        end
    end

    // Counter state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_value <= '0;
        end else begin
            r_value <= w_next;
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/hsv_core_issue_scoreboard.sv
// Issue-stage scoreboard: per-register pending-write counts gate a
// valid/ready issue handshake into a one-entry registered output stage.
module hsv_core_issue_scoreboard
    import hsv_core_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int NUM_WB   = SB_NUM_WB,
    parameter int CNT_W    = SB_CNT_W,
    parameter int DATA_W   = SB_DATA_W
) (
    input  logic                           clk_core,
    input  logic                           rst_core_n,
    input  logic                           flush_req,
    input  logic                           stall,
    input  logic                           valid_i,
    output logic                           ready_o,
    input  logic [$clog2(NUM_REGS)-1:0]    rs1_addr,
    input  logic [$clog2(NUM_REGS)-1:0]    rs2_addr,
    input  logic [$clog2(NUM_REGS)-1:0]    rd_addr,
    input  logic                           rd_we,
    input  logic [DATA_W-1:0]              data_i,
    input  logic [NUM_WB-1:0]              wb_valid,
    input  logic [NUM_WB*$clog2(NUM_REGS)-1:0] wb_addr,
    output logic                           valid_o,
    output logic [DATA_W-1:0]              data_o,
    output logic [NUM_REGS-1:0]            busy_mask,
    output logic                           err_o
);

    localparam int AW = $clog2(NUM_REGS);
    localparam int DW = $clog2(NUM_WB + 1);

    logic [CNT_W-1:0]  w_cnt [NUM_REGS];
    logic [NUM_REGS-1:0] w_uflow;
    logic              w_space;
    logic              w_hazard;
    logic              w_accept;
    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic              r_err;

    assign w_cnt[0]   = '0;
    assign w_uflow[0] = 1'b0;

    // Hazard and handshake, from registered counters only (no bypass)
    always_comb begin
        w_space  = !r_valid || !stall;
        w_hazard = 1'b0;
        if (rs1_addr != '0 && w_cnt[rs1_addr] != '0) begin
            w_hazard = 1'b1;
        end
        if (rs2_addr != '0 && w_cnt[rs2_addr] != '0) begin
            w_hazard = 1'b1;
        end
        if (rd_we && rd_addr != '0 && w_cnt[rd_addr] == '1) begin
            w_hazard = 1'b1;
        end
        ready_o  = w_space && !w_hazard && !flush_req;
        w_accept = valid_i && ready_o;
    end

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
        logic          w_inc;
        logic [DW-1:0] w_dec;

        assign w_inc = w_accept && rd_we && (rd_addr == AW'(r));

        // Number of writeback ports retiring this register this cycle
        always_comb begin
            w_dec = '0;
            for (int unsigned p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && wb_addr[p*AW +: AW] == AW'(r)) begin
                    w_dec = w_dec + DW'(1);
                end
            end
        end

        hsv_core_issue_scoreboard_cnt #(
            .CNT_W (CNT_W),
            .DEC_W (DW)
        ) u_cnt (
            .i_clk       (clk_core),
            .i_rst_n     (rst_core_n),
            .i_clr       (flush_req),
            .i_inc       (w_inc),
            .i_dec       (w_dec),
            .o_value     (w_cnt[r]),
            .o_underflow (w_uflow[r])
        );
    end

    // Busy view of the counters; x0 is never tracked
    always_comb begin
        busy_mask = '0;
        for (int unsigned r = 1; r < NUM_REGS; r++) begin
            busy_mask[r] = (w_cnt[r] != '0);
        end
    end

    // One-entry output stage; flush kills valid but leaves the payload
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush_req) begin
            r_valid <= 1'b0;
        end else if (w_space) begin
            r_valid <= w_accept;
            if (w_accept) begin
                r_data <= data_i;
            end
        end
    end

    // Sticky underflow flag, cleared only by reset
    always_ff @(posedge clk_core or negedge rst_core_n) begin
        if (!rst_core_n) begin
            r_err <= 1'b0;
        end else if (|w_uflow) begin
            r_err <= 1'b1;
        end
    end

    assign valid_o = r_valid;
    assign data_o  = r_data;
    assign err_o   = r_err;

endmodule

// File: tb/tb_hsv_core_issue_scoreboard.sv
// Directed bench for hsv_core_issue_scoreboard with hand-computed expectations.
module tb_hsv_core_issue_scoreboard;

    localparam int NUM_REGS = 32;
    localparam int NUM_WB   = 2;
    localparam int CNT_W    = 2;
    localparam int DATA_W   = 64;

    logic              clk_core = 1'b0;
    logic              rst_core_n;
    logic              flush_req, stall, valid_i, rd_we;
    logic              ready_o, valid_o, err_o;
    logic [4:0]        rs1_addr, rs2_addr, rd_addr;
    logic [DATA_W-1:0] data_i, data_o;
    logic [NUM_WB-1:0] wb_valid;
    logic [9:0]        wb_addr;
    logic [31:0]       busy_mask;

    int n_checks = 0;
    int n_errors = 0;

    hsv_core_issue_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WB   (NUM_WB),
        .CNT_W    (CNT_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk_core   (clk_core),
        .rst_core_n (rst_core_n),
        .flush_req  (flush_req),
        .stall      (stall),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .rd_addr    (rd_addr),
        .rd_we      (rd_we),
        .data_i     (data_i),
        .wb_valid   (wb_valid),
        .wb_addr    (wb_addr),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .busy_mask  (busy_mask),
        .err_o      (err_o)
    );

    always #5 clk_core = ~clk_core;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        flush_req = 1'b0; stall = 1'b0; valid_i = 1'b0; rd_we = 1'b0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; data_i = '0;
        wb_valid = '0; wb_addr = '0;
    endtask

    task automatic tick();
        @(posedge clk_core);
        #1;
    endtask

    task automatic issue(input logic [4:0] rd, input logic we, input logic [63:0] d);
        valid_i = 1'b1; rd_addr = rd; rd_we = we; data_i = d;
        rs1_addr = '0; rs2_addr = '0;
    endtask

    initial begin
        idle();
        rst_core_n = 1'b0;
        #12;
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_busy", 64'(busy_mask), 64'd0);
        rst_core_n = 1'b1;
        tick();
        chk("rst_ready", 64'(ready_o), 64'd1);

        // 1: RAW on x15 resolved by writeback, no same-cycle bypass
        issue(5'd15, 1'b1, 64'hA0A0_0000_0000_0001);
        #1 chk("t1_ready_first", 64'(ready_o), 64'd1);
        tick();
        chk("t1_valid", 64'(valid_o), 64'd1);
        chk("t1_data", data_o, 64'hA0A0_0000_0000_0001);
        chk("t1_busy15", 64'(busy_mask[15]), 64'd1);
        issue(5'd0, 1'b0, 64'hB0B0_0000_0000_0002);
        rs1_addr = 5'd15;
        #1 chk("t1_raw_block", 64'(ready_o), 64'd0);
        tick();
        wb_valid = 2'b01; wb_addr = {5'd0, 5'd15};
        #1 chk("t1_no_bypass", 64'(ready_o), 64'd0);
        tick();
        wb_valid = '0;
        #1 chk("t1_ready_after_wb", 64'(ready_o), 64'd1);
        chk("t1_busy15_clear", 64'(busy_mask[15]), 64'd0);
        tick();
        chk("t1_data_b", data_o, 64'hB0B0_0000_0000_0002);

        // 2: WAW up to saturation on x7
        for (int i = 0; i < 3; i++) begin
            issue(5'd7, 1'b1, 64'(i + 16'h700));
            #1 chk("t2_ready_waw", 64'(ready_o), 64'd1);
            tick();
        end
        chk("t2_data_last", data_o, 64'h702);
        chk("t2_busy7", 64'(busy_mask[7]), 64'd1);
        issue(5'd7, 1'b1, 64'h703);
        #1 chk("t2_sat_block", 64'(ready_o), 64'd0);
        wb_valid = 2'b01; wb_addr = {5'd0, 5'd7};
        #1 chk("t2_sat_wb_same", 64'(ready_o), 64'd0);
        tick();
        wb_valid = '0;
        #1 chk("t2_ready_after_wb", 64'(ready_o), 64'd1);
        tick();
        chk("t2_data_4th", data_o, 64'h703);
        valid_i = 1'b0;
        wb_valid = 2'b11; wb_addr = {5'd7, 5'd7};
        tick();
        chk("t2_busy7_after2", 64'(busy_mask[7]), 64'd1);
        wb_valid = 2'b10; wb_addr = {5'd7, 5'd0};
        tick();
        wb_valid = '0;
        chk("t2_busy7_clear", 64'(busy_mask[7]), 64'd0);
        chk("t2_err", 64'(err_o), 64'd0);

        // 3: net update with issue and two writebacks on x9
        issue(5'd9, 1'b1, 64'h900); tick();
        issue(5'd9, 1'b1, 64'h901); tick();
        issue(5'd9, 1'b1, 64'h902);
        wb_valid = 2'b11; wb_addr = {5'd9, 5'd9};
        #1 chk("t3_ready", 64'(ready_o), 64'd1);
        tick();
        idle();
        chk("t3_busy9_net1", 64'(busy_mask[9]), 64'd1);
        chk("t3_err", 64'(err_o), 64'd0);
        wb_valid = 2'b01; wb_addr = {5'd0, 5'd9};
        tick();
        wb_valid = '0;
        chk("t3_busy9_zero", 64'(busy_mask[9]), 64'd0);
        chk("t3_err_after", 64'(err_o), 64'd0);

        // 4: stall holds output stage, then back-to-back accepts
        issue(5'd0, 1'b0, 64'hC0C0); tick();
        issue(5'd0, 1'b0, 64'hD0D0);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("t4_stall_ready", 64'(ready_o), 64'd0);
            tick();
            chk("t4_stall_data", data_o, 64'hC0C0);
            chk("t4_stall_valid", 64'(valid_o), 64'd1);
        end
        stall = 1'b0;
        #1 chk("t4_release_ready", 64'(ready_o), 64'd1);
        tick();
        chk("t4_data_d", data_o, 64'hD0D0);
        issue(5'd0, 1'b0, 64'hE0E0);
        #1 chk("t4_b2b_ready", 64'(ready_o), 64'd1);
        tick();
        chk("t4_data_e", data_o, 64'hE0E0);
        valid_i = 1'b0;
        tick();
        chk("t4_drain", 64'(valid_o), 64'd0);

        // 5: flush clears tracking and drops the same-cycle issue
        issue(5'd3, 1'b1, 64'h3); tick();
        issue(5'd5, 1'b1, 64'h5); tick();
        issue(5'd12, 1'b1, 64'hC); tick();
        chk("t5_busy", 64'(busy_mask), 64'h0000_1028);
        issue(5'd20, 1'b1, 64'hF0F0);
        flush_req = 1'b1;
        #1 chk("t5_flush_ready", 64'(ready_o), 64'd0);
        tick();
        idle();
        chk("t5_busy_zero", 64'(busy_mask), 64'd0);
        chk("t5_valid_zero", 64'(valid_o), 64'd0);
        chk("t5_data_kept", data_o, 64'hC);

        // 6: x0 writeback is ignored, underflow is sticky across flush
        wb_valid = 2'b01; wb_addr = {5'd0, 5'd0};
        tick();
        chk("t6_x0_no_err", 64'(err_o), 64'd0);
        wb_valid = 2'b10; wb_addr = {5'd4, 5'd0};
        tick();
        wb_valid = '0;
        chk("t6_underflow", 64'(err_o), 64'd1);
        chk("t6_busy4", 64'(busy_mask[4]), 64'd0);
        flush_req = 1'b1; tick(); flush_req = 1'b0;
        chk("t6_err_sticky", 64'(err_o), 64'd1);
        issue(5'd6, 1'b1, 64'h6666); tick();
        idle();
        chk("t6_pre_rst_valid", 64'(valid_o), 64'd1);
        #2 rst_core_n = 1'b0;
        #1;
        chk("t6_arst_valid", 64'(valid_o), 64'd0);
        chk("t6_arst_data", data_o, 64'd0);
        chk("t6_arst_busy", 64'(busy_mask), 64'd0);
        chk("t6_arst_err", 64'(err_o), 64'd0);
        rst_core_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
